fifo_ptr_ctrl: RTL and testbench

Parametrised pointer and status controller for single-port-RAM-backed FIFOs. It generalises the fixed 8-entry address updater to any power-of-two depth and adds:
- a registered occupancy count
- programmable almost-full and almost-empty thresholds
- explicit accept strobes for the storage array
- optional sticky overflow/underflow error flags

It sits between the FIFO's push/pop requesters and the SPRAM address/enable pins.

---
 rtl/fifo_ptr_ctrl_if.sv | 37 +++
 rtl/fifo_ptr_ctrl.sv | 100 ++++++++++
 tb/tb_fifo_ptr_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/fifo_ptr_ctrl_if.sv
// fifo_ptr_ctrl_if
// Bundles the push/pop requests and the pointer/status outputs of
// fifo_ptr_ctrl so that one connection carries the whole FIFO control bus.
//   master : requester side; drives we/re/err_clr and observes the status.
//   slave  : controller side; drives addresses, strobes, flags, count and errors.
// Signals: we, re, err_clr, w_adr, r_adr, w_acc, r_acc, full, empty,
//          almost_full, almost_empty, count, overflow, underflow.
interface fifo_ptr_ctrl_if #(
  parameter int ADDR_WIDTH = 3
);
  logic                  we;
  logic                  re;
  logic                  err_clr;
  logic [ADDR_WIDTH-1:0] w_adr;
  logic [ADDR_WIDTH-1:0] r_adr;
  logic                  w_acc;
  logic                  r_acc;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output we, re, err_clr,
    input  w_adr, r_adr, w_acc, r_acc, full, empty,
    input  almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  we, re, err_clr,
    output w_adr, r_adr, w_acc, r_acc, full, empty,
    output almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_ptr_ctrl.sv
// fifo_ptr_ctrl
// Pointer and status controller for a single-port-RAM-backed FIFO of depth
// 2^ADDR_WIDTH. Generates RAM write/read addresses and enables, an occupancy
// count, full/empty and programmable almost-full/almost-empty flags.
// Ports:
//   clk  - single clock, all state on the rising edge
//   rst  - synchronous active-high reset
//   bus  - fifo_ptr_ctrl_if.slave (we, re, err_clr in; addresses, accept
//          strobes, flags, count, overflow/underflow out)
// Optional feature: define FIFO_PTR_ERR_EN to build sticky overflow and
// underflow flags cleared by err_clr; otherwise both are tied to 0.
module fifo_ptr_ctrl #(
  parameter int ADDR_WIDTH = 3,
  parameter int AF_TH      = 6,
  parameter int AE_TH      = 2
) (
  input  logic            clk,
  input  logic            rst,
  fifo_ptr_ctrl_if.slave  bus
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] AF_LVL = PW'(AF_TH);
  localparam logic [ADDR_WIDTH:0] AE_LVL = PW'(AE_TH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH:0] rd_ptr;
  logic [ADDR_WIDTH:0] count;
  logic                full;
  logic                empty;
  logic                w_acc;
  logic                r_acc;

  // Flag decode: registers only, so flags never depend on this cycle's requests.
  always_comb begin
    empty = (wr_ptr == rd_ptr);
    full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
            (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
  end

  // A push while full is only taken if a pop frees the slot on the same edge.
  assign r_acc = bus.re & ~empty;
  assign w_acc = bus.we & (~full | bus.re);

  // Register update: pointers and count advance together so count always
  // equals wr_ptr - rd_ptr.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (w_acc) wr_ptr <= wr_ptr + 1'b1;
      if (r_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({w_acc, r_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef FIFO_PTR_ERR_EN
  logic overflow;
  logic underflow;

  // Sticky error flags; a set event in the clearing cycle wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (bus.we & full & ~bus.re) overflow <= 1'b1;
      else if (bus.err_clr)        overflow <= 1'b0;
      if (bus.re & empty)          underflow <= 1'b1;
      else if (bus.err_clr)        underflow <= 1'b0;
    end
  end

  assign bus.overflow  = overflow;
  assign bus.underflow = underflow;
`else
  logic unused_err_clr;
  assign unused_err_clr = bus.err_clr;
  assign bus.overflow   = 1'b0;
  assign bus.underflow  = 1'b0;
`endif

  assign bus.w_adr        = wr_ptr[ADDR_WIDTH-1:0];
  assign bus.r_adr        = rd_ptr[ADDR_WIDTH-1:0];
  assign bus.w_acc        = w_acc;
  assign bus.r_acc        = r_acc;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count >= AF_LVL);
  assign bus.almost_empty = (count <= AE_LVL);
  assign bus.count        = count;

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Bench for fifo_ptr_ctrl at the default parameters (depth 8, AF 6, AE 2).
// An occupancy/index model checks every output on each falling edge, and the
// directed sequence pins specific values by hand.
module tb_fifo_ptr_ctrl;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;
`ifdef FIFO_PTR_ERR_EN
  localparam int ERR_ON = 1;
`else
  localparam int ERR_ON = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  fifo_ptr_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  fifo_ptr_ctrl #(.ADDR_WIDTH(AW), .AF_TH(AF), .AE_TH(AE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: occupancy plus push/pop totals modulo depth.
  int m_cnt = 0, m_w = 0, m_r = 0, m_ovf = 0, m_unf = 0;
  bit started = 0;

  initial begin
    forever begin
      int wacc, racc;
      @(negedge clk);
      racc = (bus.re && m_cnt > 0) ? 1 : 0;
      wacc = (bus.we && (m_cnt < DEPTH || bus.re)) ? 1 : 0;
      if (started) begin
        chk("m_w_adr", int'(bus.w_adr), m_w);
        chk("m_r_adr", int'(bus.r_adr), m_r);
        chk("m_count", int'(bus.count), m_cnt);
        chk("m_full", int'(bus.full), int'(m_cnt == DEPTH));
        chk("m_empty", int'(bus.empty), int'(m_cnt == 0));
        chk("m_afull", int'(bus.almost_full), int'(m_cnt >= AF));
        chk("m_aempty", int'(bus.almost_empty), int'(m_cnt <= AE));
        chk("m_w_acc", int'(bus.w_acc), wacc);
        chk("m_r_acc", int'(bus.r_acc), racc);
        chk("m_ovf", int'(bus.overflow), m_ovf);
        chk("m_unf", int'(bus.underflow), m_unf);
      end
      if (rst) begin
        m_cnt = 0; m_w = 0; m_r = 0; m_ovf = 0; m_unf = 0;
        started = 1;
      end else begin
        if (ERR_ON == 1) begin
          if (bus.we && m_cnt == DEPTH && !bus.re) m_ovf = 1;
          else if (bus.err_clr) m_ovf = 0;
          if (bus.re && m_cnt == 0) m_unf = 1;
          else if (bus.err_clr) m_unf = 0;
        end
        m_cnt = m_cnt + wacc - racc;
        m_w   = (m_w + wacc) % DEPTH;
        m_r   = (m_r + racc) % DEPTH;
      end
    end
  end

  task automatic drive(input logic w, input logic r, input logic c, input logic rs);
    bus.we = w; bus.re = r; bus.err_clr = c; rst = rs;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_count", int'(bus.count), 0);
    chk("rst_empty", int'(bus.empty), 1);
    chk("rst_aempty", int'(bus.almost_empty), 1);
    chk("rst_full", int'(bus.full), 0);
    chk("rst_afull", int'(bus.almost_full), 0);
    chk("rst_adr", int'({bus.w_adr, bus.r_adr}), 0);
    chk("rst_err", int'({bus.overflow, bus.underflow}), 0);

    // Eight pushes into an empty FIFO.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      #1;
      chk("fill_w_adr", int'(bus.w_adr), i);
      chk("fill_w_acc", int'(bus.w_acc), 1);
      tick();
      chk("fill_count", int'(bus.count), i + 1);
      chk("fill_aempty", int'(bus.almost_empty), int'(i + 1 <= 2));
      chk("fill_afull", int'(bus.almost_full), int'(i + 1 >= 6));
      chk("fill_full", int'(bus.full), int'(i + 1 == 8));
    end
    chk("fill_w_wrap", int'(bus.w_adr), 0);

    // Ninth push with no pop is refused.
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("ovf_w_acc", int'(bus.w_acc), 0);
    tick();
    chk("ovf_count", int'(bus.count), 8);
    chk("ovf_flag", int'(bus.overflow), ERR_ON);

    // Push+pop while full.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      #1;
      chk("fullrw_w_acc", int'(bus.w_acc), 1);
      chk("fullrw_r_acc", int'(bus.r_acc), 1);
      tick();
      chk("fullrw_count", int'(bus.count), 8);
    end
    chk("fullrw_w_adr", int'(bus.w_adr), 3);
    chk("fullrw_r_adr", int'(bus.r_adr), 3);

    // Drain to empty.
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      tick();
    end
    chk("drain_count", int'(bus.count), 0);
    chk("drain_empty", int'(bus.empty), 1);
    chk("drain_r_adr", int'(bus.r_adr), 3);

    // Push+pop while empty: only the push lands.
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    chk("emptyrw_r_acc", int'(bus.r_acc), 0);
    chk("emptyrw_w_acc", int'(bus.w_acc), 1);
    tick();
    chk("emptyrw_count", int'(bus.count), 1);
    chk("emptyrw_empty", int'(bus.empty), 0);
    chk("unf_flag", int'(bus.underflow), ERR_ON);
    chk("ovf_sticky", int'(bus.overflow), ERR_ON);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("clr_unf", int'(bus.underflow), 0);
    chk("clr_ovf", int'(bus.overflow), 0);

    // Up to count 5, then alternate push/pop across the wrap.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
    end
    chk("alt_start_count", int'(bus.count), 5);
    chk("alt_start_w_adr", int'(bus.w_adr), 0);
    for (int i = 0; i < 20; i++) begin
      drive(i % 2 == 0, i % 2 == 1, 1'b0, 1'b0);
      tick();
      chk("alt_count", int'(bus.count), (i % 2 == 0) ? 6 : 5);
      chk("alt_afull", int'(bus.almost_full), (i % 2 == 0) ? 1 : 0);
      chk("alt_full_empty", int'({bus.full, bus.empty}), 0);
    end
    chk("alt_w_adr", int'(bus.w_adr), 2);
    chk("alt_r_adr", int'(bus.r_adr), 5);

    // Reset at count 4 with a push pending.
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("prerst_count", int'(bus.count), 4);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    chk("midrst_count", int'(bus.count), 0);
    chk("midrst_empty", int'(bus.empty), 1);
    chk("midrst_adr", int'({bus.w_adr, bus.r_adr}), 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
